mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port access arbiter sitting directly upstream of the 16-bit data memory. It merges the instruction-fetch stream and the load/store stream onto the memory's one address/data/write-enable port. It uses fixed data priority with a starvation guard for fetch, registers read data into one-cycle response pulses, and optionally traps misaligned (odd byte) addresses.

## Interface
- STARVE_LIMIT, 4: consecutive cycles fetch may be denied before it is forced ahead of load/store; legal range 1..15.
- clk  in  1  rising-edge clock shared with memory.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  16  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  16  fetched word (registered).
- ls_req  in  1  load/store request; held until granted.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  16  load/store byte address.
- ls_wdata  in  16  store data.
- ls_gnt  out  1  load/store accepted this cycle (combinational).
- ls_rvalid  out  1  one-cycle completion pulse for loads and stores.
- ls_rdata  out  16  load data (registered); holds its previous value after a store.
- mem_addr  out  16  byte address to memory; memory uses bits [10:1].
- mem_din  out  16  write data to memory.
- mem_we  out  1  memory write enable.
- mem_dout  in  16  asynchronous read data from memory.
- fault  out  1  misaligned-access pulse; constant 0 without the macro.
- fault_addr  out  16  address of the most recent fault; 0 without the macro.

## Operation
- At most one grant per cycle. The winner's address drives mem_addr in the same cycle.
- Priority: ls wins by default. If starve_cnt == STARVE_LIMIT and if_req is high, if wins.
- starve_cnt: increments (saturating at STARVE_LIMIT) each cycle if_req=1 and if_gnt=0. It clears on if_gnt or when if_req=0.
- Load/fetch read: mem_dout is captured at the grant cycle's edge into the requester's rdata register, and that requester's rvalid is set.
- Store: mem_we = ls_gnt & ls_we and mem_din = ls_wdata. The write happens at the grant cycle's edge. ls_rvalid pulses the next cycle.
- Idle cycles (no grant): mem_we=0, mem_addr=0, mem_din=0.
- Address is passed through unchanged. Addresses ≥ 0x0800 alias in memory, and the arbiter performs no range check.

## Timing
- Grant latency: 0 cycles when uncontested.
- Response latency: rvalid exactly 1 cycle after gnt, high for 1 cycle. Back-to-back grants produce back-to-back rvalid.
- Requester rules:
  - Address, we and wdata must be stable while req=1.
  - Dropping req before gnt is allowed; it is treated as if never requested.
- Simultaneous if_req and ls_req with starve_cnt < STARVE_LIMIT: ls granted, starve_cnt+1.
- Reset values: if_rvalid=ls_rvalid=0, if_rdata=ls_rdata=0, fault=0, fault_addr=0, starve_cnt=0.
  - gnt and mem_we are forced 0 while reset_n=0.
- Reset asserted mid-access: the pending rvalid is cleared and no response is ever issued. A write whose edge coincides with reset assertion is not guaranteed to land.

## Configuration
- MEM_PORT_ARBITER_ALIGN_CHECK_EN defined:
  - A granted request with addr[0]=1 still completes its handshake (gnt, then rvalid 1 cycle later).
  - mem_we is suppressed and the returned rdata is 0x0000.
  - fault pulses together with rvalid, and fault_addr latches the offending address.
- Not defined: addr[0] is ignored (memory word-aligns), fault is tied 0 and fault_addr is tied 0x0000.

## Structure
- Shared package mem_pkg holds:
  - MEM_DATA_W=16, MEM_ADDR_W=16, MEM_WORD_ADDR_W=10;
  - port-select enum {SEL_NONE, SEL_IF, SEL_LS};
  - MEM_RDATA_FAULT=16'h0000.
- One natural sub-module: arb_starve_ctr, holding the saturating counter, STARVE_LIMIT compare and force_if output.

## Test plan
- Reset:
  - reset_n=0 with both reqs high gives both gnt=0, mem_we=0 and all outputs 0.
  - After release, ls_req (load, 0x0010) gives ls_gnt the same cycle.
- Store/load: ls store 0xBEEF at 0x0020, then load 0x0020. Required:
  - mem_we=1 for exactly one cycle;
  - ls_rvalid after each access;
  - ls_rdata=0xBEEF.
- Contention:
  - if_req and ls_req both high continuously, STARVE_LIMIT=4.
  - ls granted 4 cycles, if granted on the 5th, then ls again. The pattern repeats and if_rvalid pulses every 5th cycle.
- Back-to-back fetch: if_req held across 0x0000, 0x0002, 0x0004 (memory preloaded 0x1111, 0x2222, 0x3333) gives if_rvalid high 3 consecutive cycles with those values in order.
- Misalignment (macro on): store 0xAAAA at 0x0031. Required:
  - mem_we stays 0;
  - ls_rvalid and fault pulse together;
  - fault_addr=0x0031;
  - a load of 0x0030 returns its prior contents.
- Reset mid-access: assert reset_n=0 in the cycle after an if grant. No if_rvalid appears and if_rdata=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the 16-bit data-memory port and its arbiter.
package mem_pkg;

    localparam int unsigned MEM_DATA_W      = 16;
    localparam int unsigned MEM_ADDR_W      = 16;
    localparam int unsigned MEM_WORD_ADDR_W = 10;
    localparam int unsigned STARVE_CNT_W    = 4;

    localparam logic [MEM_DATA_W-1:0] MEM_RDATA_FAULT = 16'h0000;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_IF,
        SEL_LS
    } port_sel_e;

    // Winning request as presented to the memory port.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic                  we;
    } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive denied fetch cycles and flags when fetch must be forced ahead.
module arb_starve_ctr
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Saturating count of denied cycles; any grant or dropped request restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req || if_gnt) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter in front of the single-port 16-bit data memory.
// Optional misaligned-access trap: define MEM_PORT_ARBITER_ALIGN_CHECK_EN.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [MEM_ADDR_W-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [MEM_DATA_W-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [MEM_ADDR_W-1:0] ls_addr,
    input  logic [MEM_DATA_W-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [MEM_DATA_W-1:0] ls_rdata,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_din,
    output logic                  mem_we,
    input  logic [MEM_DATA_W-1:0] mem_dout,
    output logic                  fault,
    output logic [MEM_ADDR_W-1:0] fault_addr
);

    port_sel_e             sel;
    mem_req_t              win;
    logic                  force_if;
    logic                  misaligned;
    logic [MEM_DATA_W-1:0] rd_data;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if)
    );

    // Load/store wins unless fetch has hit its starvation limit; no grants in reset.
    always_comb begin
        sel = SEL_NONE;
        if (reset_n) begin
            if (ls_req && !(force_if && if_req)) begin
                sel = SEL_LS;
            end else if (if_req) begin
                sel = SEL_IF;
            end
        end
    end

    always_comb begin
        win = '0;
        case (sel)
            SEL_IF: begin
                win.addr = if_addr;
            end
            SEL_LS: begin
                win.addr  = ls_addr;
                win.wdata = ls_wdata;
                win.we    = ls_we;
            end
            default: begin
                win = '0;
            end
        endcase
    end

    assign if_gnt = (sel == SEL_IF);
    assign ls_gnt = (sel == SEL_LS);

`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    assign misaligned = (sel != SEL_NONE) && win.addr[0];
`else
    assign misaligned = 1'b0;
`endif

    assign mem_addr = win.addr;
    assign mem_din  = win.wdata;
    assign mem_we   = win.we && !misaligned;
    assign rd_data  = misaligned ? MEM_RDATA_FAULT : mem_dout;

    // Responses: one-cycle rvalid after each grant; rdata holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if_rvalid <= if_gnt;
            ls_rvalid <= ls_gnt;
            if (if_gnt) begin
                if_rdata <= rd_data;
            end
            if (ls_gnt && !ls_we) begin
                ls_rdata <= rd_data;
            end
        end
    end

`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    // Fault pulses alongside the faulting access's rvalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            fault <= misaligned;
            if (misaligned) begin
                fault_addr <= win.addr;
            end
        end
    end
`else
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, ls_req, ls_we;
    logic [15:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we, fault;
    logic [15:0] if_rdata, ls_rdata, mem_addr, mem_din, mem_dout, fault_addr;

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic [15:0] b2b_v   [3];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    // Memory behind the port: async read, write on the clock edge.
    assign mem_dout = mem[mem_addr[10:1]];
    always @(posedge clk) if (mem_we) mem[mem_addr[10:1]] <= mem_din;

    task automatic test_reset();
        reset_n = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
        if_addr = 16'h0002; ls_addr = 16'h0040; ls_wdata = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if ({if_gnt, ls_gnt} !== 2'b00) $display("FAIL rst_gnt got=%b exp=00", {if_gnt, ls_gnt}); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else n_pass++;
        n_total++; if ({mem_addr, mem_din} !== 32'h0) $display("FAIL rst_mem_bus got=%h exp=0", {mem_addr, mem_din}); else n_pass++;
        n_total++; if ({if_rvalid, ls_rvalid, fault} !== 3'b000) $display("FAIL rst_pulses got=%b exp=000", {if_rvalid, ls_rvalid, fault}); else n_pass++;
        n_total++; if ({if_rdata, ls_rdata, fault_addr} !== 48'h0) $display("FAIL rst_data got=%h exp=0", {if_rdata, ls_rdata, fault_addr}); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1; if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0010;
        #1;
        n_total++; if ({if_gnt, ls_gnt} !== 2'b01) $display("FAIL first_ls_gnt got=%b exp=01", {if_gnt, ls_gnt}); else n_pass++;
        n_total++; if (mem_addr !== 16'h0010) $display("FAIL first_mem_addr got=%h exp=0010", mem_addr); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ls_rvalid !== 1'b1) $display("FAIL first_ls_rvalid got=%b exp=1", ls_rvalid); else n_pass++;
        n_total++; if (ls_rdata !== ref_mem[8]) $display("FAIL first_ls_rdata got=%h exp=%h", ls_rdata, ref_mem[8]); else n_pass++;
        @(negedge clk);
        ls_req = 1'b0;
    endtask

    task automatic test_store_load();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0020; ls_wdata = 16'hBEEF;
        #1;
        n_total++; if ({ls_gnt, mem_we} !== 2'b11) $display("FAIL st_gnt_we got=%b exp=11", {ls_gnt, mem_we}); else n_pass++;
        n_total++; if (mem_din !== 16'hBEEF) $display("FAIL st_mem_din got=%h exp=beef", mem_din); else n_pass++;
        ref_mem[16] = 16'hBEEF;
        @(posedge clk); #1;
        n_total++; if (ls_rvalid !== 1'b1) $display("FAIL st_rvalid got=%b exp=1", ls_rvalid); else n_pass++;
        @(negedge clk);
        ls_we = 1'b0;
        #1;
        n_total++; if ({ls_gnt, mem_we} !== 2'b10) $display("FAIL ld_gnt_we got=%b exp=10", {ls_gnt, mem_we}); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ls_rvalid !== 1'b1) $display("FAIL ld_rvalid got=%b exp=1", ls_rvalid); else n_pass++;
        n_total++; if (ls_rdata !== 16'hBEEF) $display("FAIL ld_rdata got=%h exp=beef", ls_rdata); else n_pass++;
        @(negedge clk);
        ls_req = 1'b0;
        #1;
        n_total++; if (mem_we !== 1'b0) $display("FAIL idle_mem_we got=%b exp=0", mem_we); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ls_rvalid !== 1'b0) $display("FAIL ld_rvalid_pulse got=%b exp=0", ls_rvalid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        b2b_v[0] = 16'h1111; b2b_v[1] = 16'h2222; b2b_v[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 16'(2 * i);
            #1;
            n_total++; if (if_gnt !== 1'b1) $display("FAIL b2b_gnt[%0d] got=%b exp=1", i, if_gnt); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (if_rvalid !== 1'b1) $display("FAIL b2b_rvalid[%0d] got=%b exp=1", i, if_rvalid); else n_pass++;
            n_total++; if (if_rdata !== b2b_v[i]) $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, if_rdata, b2b_v[i]); else n_pass++;
        end
        @(negedge clk);
        if_req = 1'b0;
        @(posedge clk); #1;
        n_total++; if (if_rvalid !== 1'b0) $display("FAIL b2b_rvalid_end got=%b exp=0", if_rvalid); else n_pass++;
    endtask

    task automatic test_contention();
        logic e_if;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 16'h0004;
            ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0020;
            e_if = (k % 5 == 4);
            #1;
            n_total++; if ({if_gnt, ls_gnt} !== {e_if, !e_if}) $display("FAIL cont_gnt[%0d] got=%b exp=%b", k, {if_gnt, ls_gnt}, {e_if, !e_if}); else n_pass++;
            @(posedge clk); #1;
            n_total++; if ({if_rvalid, ls_rvalid} !== {e_if, !e_if}) $display("FAIL cont_rvalid[%0d] got=%b exp=%b", k, {if_rvalid, ls_rvalid}, {e_if, !e_if}); else n_pass++;
            if (e_if) begin
                n_total++; if (if_rdata !== 16'h3333) $display("FAIL cont_if_rdata[%0d] got=%h exp=3333", k, if_rdata); else n_pass++;
            end else begin
                n_total++; if (ls_rdata !== 16'hBEEF) $display("FAIL cont_ls_rdata[%0d] got=%h exp=beef", k, ls_rdata); else n_pass++;
            end
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    task automatic test_misalign();
        logic [15:0] e_word;
        e_word = ALIGN_EN ? ref_mem[24] : 16'hAAAA;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0031; ls_wdata = 16'hAAAA;
        #1;
        n_total++; if (ls_gnt !== 1'b1) $display("FAIL mis_gnt got=%b exp=1", ls_gnt); else n_pass++;
        n_total++; if (mem_we !== !ALIGN_EN) $display("FAIL mis_mem_we got=%b exp=%b", mem_we, !ALIGN_EN); else n_pass++;
        ref_mem[24] = e_word;
        @(posedge clk); #1;
        n_total++; if ({ls_rvalid, fault} !== {1'b1, ALIGN_EN}) $display("FAIL mis_rvalid_fault got=%b exp=%b", {ls_rvalid, fault}, {1'b1, ALIGN_EN}); else n_pass++;
        n_total++; if (fault_addr !== (ALIGN_EN ? 16'h0031 : 16'h0000)) $display("FAIL mis_fault_addr got=%h exp=%h", fault_addr, ALIGN_EN ? 16'h0031 : 16'h0000); else n_pass++;
        @(negedge clk);
        ls_we = 1'b0; ls_addr = 16'h0030;
        @(posedge clk); #1;
        n_total++; if (ls_rdata !== e_word) $display("FAIL mis_reload got=%h exp=%h", ls_rdata, e_word); else n_pass++;
        n_total++; if ({ls_rvalid, fault} !== 2'b10) $display("FAIL mis_aligned_fault got=%b exp=10", {ls_rvalid, fault}); else n_pass++;
        @(negedge clk);
        ls_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0002;
        #1;
        n_total++; if (if_gnt !== 1'b1) $display("FAIL rmid_gnt got=%b exp=1", if_gnt); else n_pass++;
        @(posedge clk);
        reset_n = 1'b0; if_req = 1'b0;
        #1;
        n_total++; if ({if_rvalid, if_rdata} !== 17'h0) $display("FAIL rmid_if got=%h exp=0", {if_rvalid, if_rdata}); else n_pass++;
        n_total++; if ({ls_rdata, fault_addr} !== 32'h0) $display("FAIL rmid_ls got=%h exp=0", {ls_rdata, fault_addr}); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if ({if_rvalid, if_rdata} !== 17'h0) $display("FAIL rmid_after got=%h exp=0", {if_rvalid, if_rdata}); else n_pass++;
    endtask

    // Randomized traffic against a cycle-level model of the arbitration rules.
    task automatic test_random();
        int unsigned m_starve = 0;
        logic        e_if, e_ls, mis, e_we, e_fault;
        logic [15:0] e_addr, rd, e_if_rdata, e_ls_rdata, e_fault_addr;
        e_if_rdata = 16'h0; e_ls_rdata = 16'h0; e_fault_addr = 16'h0;
        if_req = 1'b0; ls_req = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!if_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    if_req  = 1'b1;
                    if_addr = 16'($urandom_range(31, 0));
                    if ($urandom_range(3, 0) == 0) if_addr = if_addr | 16'h0800;
                end
            end else if ($urandom_range(7, 0) == 0) begin
                if_req = 1'b0;
            end
            if (!ls_req) begin
                if ($urandom_range(1, 0) == 1) begin
                    ls_req   = 1'b1;
                    ls_we    = 1'($urandom_range(1, 0));
                    ls_wdata = 16'($urandom_range(16'hFFFF, 0));
                    ls_addr  = 16'($urandom_range(31, 0));
                    if ($urandom_range(3, 0) == 0) ls_addr = ls_addr | 16'h0800;
                end
            end else if ($urandom_range(7, 0) == 0) begin
                ls_req = 1'b0;
            end
            e_ls   = ls_req && !(m_starve == LIMIT && if_req);
            e_if   = if_req && !e_ls;
            e_addr = e_ls ? ls_addr : (e_if ? if_addr : 16'h0);
            mis    = ALIGN_EN && (e_ls || e_if) && e_addr[0];
            e_we   = e_ls && ls_we && !mis;
            #1;
            n_total++; if ({if_gnt, ls_gnt} !== {e_if, e_ls}) $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, {if_gnt, ls_gnt}, {e_if, e_ls}); else n_pass++;
            n_total++; if ({mem_addr, mem_we} !== {e_addr, e_we}) $display("FAIL rnd_mem[%0d] got=%h/%b exp=%h/%b", c, mem_addr, mem_we, e_addr, e_we); else n_pass++;
            if (!(e_if || e_ls) || e_we) begin
                n_total++; if (mem_din !== (e_we ? ls_wdata : 16'h0)) $display("FAIL rnd_din[%0d] got=%h exp=%h", c, mem_din, e_we ? ls_wdata : 16'h0); else n_pass++;
            end
            rd = mis ? 16'h0000 : ref_mem[e_addr[10:1]];
            if (e_if) e_if_rdata = rd;
            if (e_ls && !ls_we) e_ls_rdata = rd;
            if (e_we) ref_mem[e_addr[10:1]] = ls_wdata;
            e_fault = mis;
            if (mis) e_fault_addr = e_addr;
            if (if_req && !e_if) begin
                if (m_starve < LIMIT) m_starve++;
            end else begin
                m_starve = 0;
            end
            @(posedge clk); #1;
            n_total++; if ({if_rvalid, ls_rvalid, fault} !== {e_if, e_ls, e_fault}) $display("FAIL rnd_pulses[%0d] got=%b exp=%b", c, {if_rvalid, ls_rvalid, fault}, {e_if, e_ls, e_fault}); else n_pass++;
            n_total++; if ({if_rdata, ls_rdata} !== {e_if_rdata, e_ls_rdata}) $display("FAIL rnd_rdata[%0d] got=%h/%h exp=%h/%h", c, if_rdata, ls_rdata, e_if_rdata, e_ls_rdata); else n_pass++;
            n_total++; if (fault_addr !== e_fault_addr) $display("FAIL rnd_fault_addr[%0d] got=%h exp=%h", c, fault_addr, e_fault_addr); else n_pass++;
            if (e_if) if_req = 1'b0;
            if (e_ls) ls_req = 1'b0;
        end
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] <= 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        mem[0] <= 16'h1111; mem[1] <= 16'h2222; mem[2] <= 16'h3333; mem[24] <= 16'h5A5A;
        ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[2] = 16'h3333; ref_mem[24] = 16'h5A5A;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_contention();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
